// File: rtl/stripes_pkg.sv
// Shared constants, types and helpers for the brick shuffle/unshuffle datapath.
package stripes_pkg;

    localparam int DEF_BL         = 256;  // brick length in bits
    localparam int DEF_IN_BRICKS  = 16;   // bricks arriving per input beat
    localparam int DEF_OUT_BRICKS = 16;   // slots in an assembled row
    localparam int DEF_SEL_BITS   = 4;    // destination-slot tag width

    typedef logic [DEF_BL-1:0] brick_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } unshuf_state_t;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unshuffle_slot_sel.sv
// Per-slot selector: finds whether any enabled brick of the current beat
// targets this slot and, if several do, picks the lowest-numbered one.
module unshuffle_slot_sel
    import stripes_pkg::*;
#(
    parameter int IN_BRICKS = DEF_IN_BRICKS,
    parameter int SEL_BITS  = DEF_SEL_BITS,
    parameter int WIN_BITS  = idx_bits(DEF_IN_BRICKS)
) (
    input  logic [SEL_BITS*IN_BRICKS-1:0] i_sel,
    input  logic [IN_BRICKS-1:0]          i_en,
    input  logic [SEL_BITS-1:0]           i_slot,
    output logic                          o_hit,
    output logic [WIN_BITS-1:0]           o_win
);

    logic                hit_s;
    logic [WIN_BITS-1:0] win_s;

    // Scan from the highest brick down so the lowest matching brick is the last writer.
    always_comb begin
        hit_s = 1'b0;
        win_s = '0;
        for (int k = IN_BRICKS - 1; k >= 0; k--) begin
            if (i_en[k] && (i_sel[k*SEL_BITS +: SEL_BITS] == i_slot)) begin
                hit_s = 1'b1;
                win_s = WIN_BITS'(k);
            end else begin
                hit_s = hit_s;
                win_s = win_s;
            end
        end
    end

    assign o_hit = hit_s;
    assign o_win = win_s;

endmodule

// File: rtl/brick_unshuffler.sv
// Brick unshuffler: scatters tagged bricks from incoming beats into a row
// register and hands the row downstream once it is full or explicitly closed.
module brick_unshuffler
    import stripes_pkg::*;
#(
    parameter int BL         = DEF_BL,
    parameter int IN_BRICKS  = DEF_IN_BRICKS,
    parameter int OUT_BRICKS = DEF_OUT_BRICKS,
    parameter int SEL_BITS   = DEF_SEL_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [IN_BRICKS*BL-1:0]       i_data,
    input  logic [SEL_BITS*IN_BRICKS-1:0] i_sel,
    input  logic [IN_BRICKS-1:0]          i_en,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [OUT_BRICKS*BL-1:0]      o_data,
    output logic [OUT_BRICKS-1:0]         o_mask
);

    localparam int WIN_BITS = idx_bits(IN_BRICKS);

    unshuf_state_t         state_q, state_d;
    logic [OUT_BRICKS-1:0] mask_q, mask_d;
    logic [BL-1:0]         slot_q [OUT_BRICKS];
    logic [BL-1:0]         slot_d [OUT_BRICKS];
    logic [OUT_BRICKS-1:0] hit_s;
    logic [WIN_BITS-1:0]   win_s  [OUT_BRICKS];
    logic                  accept_s;

    // Ready only while filling and out of reset; a drained row frees the
    // input on the following cycle, never in the same one.
    assign i_ready  = (state_q == FILL) && !rst;
    assign accept_s = i_valid && i_ready;

    genvar j;
    generate
        for (j = 0; j < OUT_BRICKS; j++) begin : g_slot
            unshuffle_slot_sel #(
                .IN_BRICKS (IN_BRICKS),
                .SEL_BITS  (SEL_BITS),
                .WIN_BITS  (WIN_BITS)
            ) u_sel (
                .i_sel  (i_sel),
                .i_en   (i_en),
                .i_slot (SEL_BITS'(j)),
                .o_hit  (hit_s[j]),
                .o_win  (win_s[j])
            );
            assign o_data[j*BL +: BL] = slot_q[j];
        end
    endgenerate

    assign o_valid = (state_q == DRAIN);
    assign o_mask  = mask_q;

    // Next-state logic: scatter winning bricks while filling, clear the row when it is consumed.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        for (int s = 0; s < OUT_BRICKS; s++) begin
            slot_d[s] = slot_q[s];
        end
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    for (int s = 0; s < OUT_BRICKS; s++) begin
                        if (hit_s[s]) begin
                            slot_d[s] = i_data[int'(win_s[s])*BL +: BL];
                            mask_d[s] = 1'b1;
                        end else begin
                            slot_d[s] = slot_q[s];
                            mask_d[s] = mask_q[s];
                        end
                    end
                    if ((&mask_d) || i_last) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (o_ready) begin
                    state_d = FILL;
                    mask_d  = '0;
                    for (int s = 0; s < OUT_BRICKS; s++) begin
                        slot_d[s] = '0;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FILL;
                mask_d  = '0;
                for (int s = 0; s < OUT_BRICKS; s++) begin
                    slot_d[s] = '0;
                end
            end
        endcase
    end

    // State, mask and slot registers; reset discards any partial row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            mask_q  <= '0;
            for (int s = 0; s < OUT_BRICKS; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            for (int s = 0; s < OUT_BRICKS; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

endmodule

// File: tb/tb_brick_unshuffler.sv
// Directed self-checking bench for brick_unshuffler.
module tb_brick_unshuffler;

    localparam int BL = 256;
    localparam int NB = 16;
    localparam int SB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid;
    logic            i_ready;
    logic [NB*BL-1:0] i_data;
    logic [SB*NB-1:0] i_sel;
    logic [NB-1:0]   i_en;
    logic            i_last;
    logic            o_valid;
    logic            o_ready;
    logic [NB*BL-1:0] o_data;
    logic [NB-1:0]   o_mask;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [BL-1:0] exp_s [NB];
    int            sel_a [NB];

    always #5 clk = ~clk;

    brick_unshuffler dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_sel   (i_sel),
        .i_en    (i_en),
        .i_last  (i_last),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_mask  (o_mask)
    );

    function automatic logic [BL-1:0] mk_brick(input int seed, input int k);
        logic [31:0] w;
        w = {seed[15:0], k[15:0]};
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag);
        logic [NB*BL-1:0] e;
        int bad;
        bad = 0;
        for (int j = 0; j < NB; j++) begin
            e[j*BL +: BL] = exp_s[j];
        end
        for (int j = NB - 1; j >= 0; j--) begin
            if (o_data[j*BL +: BL] !== exp_s[j]) bad = j;
        end
        checks++;
        assert (o_data === e) passes++;
        else begin
            fails++;
            $error("FAIL %s: slot %0d low word got %h expected %h", tag, bad,
                   o_data[bad*BL +: 32], exp_s[bad][31:0]);
        end
    endtask

    task automatic clr_exp();
        for (int j = 0; j < NB; j++) exp_s[j] = '0;
    endtask

    task automatic drive_beat(input int seed, input logic [NB-1:0] en, input logic last);
        for (int k = 0; k < NB; k++) begin
            i_data[k*BL +: BL] = mk_brick(seed, k);
            i_sel[k*SB +: SB]  = 4'(sel_a[k]);
        end
        i_en    = en;
        i_last  = last;
        i_valid = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_sel   = '0;
        i_en    = '0;
        i_last  = 1'b0;
        o_ready = 1'b0;
        tick();
        tick();
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_mask",  32'(o_mask),  32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_i_ready", 32'(i_ready), 32'd1);

        // 1. Identity beat fills every slot in one go
        for (int k = 0; k < NB; k++) sel_a[k] = k;
        drive_beat(1, 16'hFFFF, 1'b0);
        tick();
        i_valid = 1'b0;
        for (int j = 0; j < NB; j++) exp_s[j] = mk_brick(1, j);
        chk("id_o_valid", 32'(o_valid), 32'd1);
        chk("id_o_mask",  32'(o_mask),  32'h0000FFFF);
        chk("id_i_ready", 32'(i_ready), 32'd0);
        chk_data("id_o_data");
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("id_drain_o_valid", 32'(o_valid), 32'd0);
        chk("id_drain_i_ready", 32'(i_ready), 32'd1);
        chk("id_drain_o_mask",  32'(o_mask),  32'd0);

        // Idle cycles with garbage inputs change nothing
        i_en = 16'hFFFF;
        i_last = 1'b1;
        tick();
        tick();
        chk("idle_o_valid", 32'(o_valid), 32'd0);
        chk("idle_o_mask",  32'(o_mask),  32'd0);

        // 2. Two-beat fill: reversed half, then identity half
        for (int k = 0; k < NB; k++) sel_a[k] = 15 - k;
        drive_beat(2, 16'h00FF, 1'b0);
        tick();
        i_valid = 1'b0;
        chk("two_b1_o_valid", 32'(o_valid), 32'd0);
        chk("two_b1_o_mask",  32'(o_mask),  32'h0000FF00);
        tick();
        chk("two_idle_o_mask", 32'(o_mask), 32'h0000FF00);
        for (int k = 0; k < NB; k++) sel_a[k] = k;
        drive_beat(3, 16'h00FF, 1'b0);
        tick();
        i_valid = 1'b0;
        for (int j = 0; j < 8; j++) exp_s[j] = mk_brick(3, j);
        for (int j = 8; j < NB; j++) exp_s[j] = mk_brick(2, 15 - j);
        chk("two_o_valid", 32'(o_valid), 32'd1);
        chk("two_o_mask",  32'(o_mask),  32'h0000FFFF);
        chk_data("two_o_data");
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;

        // Rewrite of a filled slot in a later beat overwrites data, keeps mask
        for (int k = 0; k < NB; k++) sel_a[k] = 0;
        sel_a[0] = 4;
        drive_beat(4, 16'h0001, 1'b0);
        tick();
        i_valid = 1'b0;
        chk("rw_b1_o_valid", 32'(o_valid), 32'd0);
        chk("rw_b1_o_mask",  32'(o_mask),  32'h00000010);
        drive_beat(5, 16'h0001, 1'b1);
        tick();
        i_valid = 1'b0;
        clr_exp();
        exp_s[4] = mk_brick(5, 0);
        chk("rw_o_valid", 32'(o_valid), 32'd1);
        chk("rw_o_mask",  32'(o_mask),  32'h00000010);
        chk_data("rw_o_data");
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;

        // 3. Conflict: bricks 3 and 9 both target slot 5, lowest wins
        for (int k = 0; k < NB; k++) sel_a[k] = 0;
        sel_a[3] = 5;
        sel_a[9] = 5;
        drive_beat(6, 16'h0208, 1'b1);
        tick();
        i_valid = 1'b0;
        clr_exp();
        exp_s[5] = mk_brick(6, 3);
        chk("cf_o_valid", 32'(o_valid), 32'd1);
        chk("cf_o_mask",  32'(o_mask),  32'h00000020);
        chk_data("cf_o_data");
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;

        // 4. Partial close into slot 12, then 5. backpressure
        for (int k = 0; k < NB; k++) sel_a[k] = 0;
        sel_a[0] = 12;
        drive_beat(7, 16'h0001, 1'b1);
        tick();
        clr_exp();
        exp_s[12] = mk_brick(7, 0);
        chk("pc_o_valid", 32'(o_valid), 32'd1);
        chk("pc_o_mask",  32'(o_mask),  32'h00001000);
        chk_data("pc_o_data");
        // keep offering a full beat while stalled; it must not be taken
        for (int k = 0; k < NB; k++) sel_a[k] = k;
        drive_beat(9, 16'hFFFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_mask",  32'(o_mask),  32'h00001000);
            chk("bp_i_ready", 32'(i_ready), 32'd0);
            chk_data("bp_o_data");
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("bp_rel_o_valid", 32'(o_valid), 32'd0);
        chk("bp_rel_i_ready", 32'(i_ready), 32'd1);
        chk("bp_rel_o_mask",  32'(o_mask),  32'd0);

        // i_last with no hits still emits an empty row
        drive_beat(10, 16'h0000, 1'b1);
        tick();
        i_valid = 1'b0;
        clr_exp();
        chk("empty_o_valid", 32'(o_valid), 32'd1);
        chk("empty_o_mask",  32'(o_mask),  32'd0);
        chk_data("empty_o_data");
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;

        // 6. Reset while draining with o_ready low
        for (int k = 0; k < NB; k++) sel_a[k] = k;
        drive_beat(8, 16'hFFFF, 1'b0);
        tick();
        i_valid = 1'b0;
        chk("r6_o_valid_pre", 32'(o_valid), 32'd1);
        rst = 1'b1;
        tick();
        clr_exp();
        chk("r6_o_valid", 32'(o_valid), 32'd0);
        chk("r6_o_mask",  32'(o_mask),  32'd0);
        chk("r6_i_ready", 32'(i_ready), 32'd0);
        chk_data("r6_o_data");
        tick();
        chk("r6_hold_i_ready", 32'(i_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("r6_rel_i_ready", 32'(i_ready), 32'd1);
        chk("r6_rel_o_valid", 32'(o_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
